// File: rtl/cart_sram_pkg.sv
// Shared types and constants for the cartridge SRAM backup store.
package cart_sram_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    NEXT
  } state_e;

  typedef enum logic {
    OP_LOAD,
    OP_SAVE
  } op_e;

endpackage

// File: rtl/cart_sram_dpram.sv
// True dual-port byte RAM, registered reads on both ports, no reset.
module cart_sram_dpram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [7:0]        a_din_i,
  input  logic              a_we_i,
  input  logic              a_en_i,
  output logic [7:0]        a_dout_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [7:0]        b_din_i,
  input  logic              b_we_i,
  output logic [7:0]        b_dout_o
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] a_dout_q;
  logic [7:0] b_dout_q;

  always_ff @(posedge clk) begin
    if (a_we_i) mem[a_addr_i] <= a_din_i;
    if (b_we_i) mem[b_addr_i] <= b_din_i;
    if (a_en_i) a_dout_q <= mem[a_addr_i];
    b_dout_q <= mem[b_addr_i];
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/cart_sram_backup.sv
// Battery-backed cartridge SRAM with sector load/save to a mounted image.
// Optional idle autosave is compiled in with `define CART_SRAM_AUTOSAVE_EN.
module cart_sram_backup
  import cart_sram_pkg::*;
#(
  parameter int ADDR_W          = 13,
  parameter int AUTOSAVE_CYCLES = 10_738_635
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  input  logic              cpu_oe,
  output logic [7:0]        cpu_dout,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [31:0]       img_size,
  input  logic              save_req,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic              busy,
  output logic              dirty
);

  localparam int SIDX_W = (ADDR_W > SECTOR_AW) ? ADDR_W - SECTOR_AW : 1;
  localparam logic [SIDX_W-1:0] LAST_SECTOR = SIDX_W'((1 << (ADDR_W - SECTOR_AW)) - 1);

  state_e            state_q;
  op_e               op_q;
  logic [SIDX_W-1:0] sector_idx_q;
  logic [SIDX_W-1:0] sector_nxt;
  logic              load_pend_q, save_pend_q;
  logic              img_present_q, img_ro_q;
  logic              present_d, ro_d, can_save, save_queue;
  logic [31:0]       sd_lba_q;
  logic              sd_rd_q, sd_wr_q, busy_q, dirty_q;
  logic              rd_seen_q, b_seen_q;
  logic              autosave_hit;
  logic [ADDR_W-1:0] b_addr;
  logic              b_we;
  logic [7:0]        a_dout, b_dout;

  // A mount in the same cycle as a save request decides against the new image.
  always_comb begin
    present_d = img_present_q;
    ro_d      = img_ro_q;
    if (img_mounted) begin
      present_d = (img_size != 32'd0);
      ro_d      = img_readonly;
    end
    can_save = present_d && !ro_d;
  end

  assign save_queue = can_save && (save_req || autosave_hit);
  assign sector_nxt = sector_idx_q + 1'b1;
  assign b_addr     = ADDR_W'({sector_idx_q, sd_buff_addr});
  assign b_we       = sd_buff_wr && sd_ack && (op_q == OP_LOAD) &&
                      ((state_q == REQ) || (state_q == XFER));

  cart_sram_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .a_addr_i (cpu_addr),
    .a_din_i  (cpu_din),
    .a_we_i   (cpu_we),
    .a_en_i   (cpu_oe),
    .a_dout_o (a_dout),
    .b_addr_i (b_addr),
    .b_din_i  (sd_buff_dout),
    .b_we_i   (b_we),
    .b_dout_o (b_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_LOAD;
      sector_idx_q  <= '0;
      load_pend_q   <= 1'b0;
      save_pend_q   <= 1'b0;
      img_present_q <= 1'b0;
      img_ro_q      <= 1'b0;
      sd_lba_q      <= '0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      busy_q        <= 1'b0;
      dirty_q       <= 1'b0;
    end else begin
      img_present_q <= present_d;
      img_ro_q      <= ro_d;
      case (state_q)
        IDLE: begin
          if (load_pend_q || save_pend_q) begin
            if (load_pend_q) begin
              op_q        <= OP_LOAD;
              load_pend_q <= 1'b0;
              sd_rd_q     <= 1'b1;
            end else begin
              op_q        <= OP_SAVE;
              save_pend_q <= 1'b0;
              sd_wr_q     <= 1'b1;
              dirty_q     <= 1'b0;
            end
            sd_lba_q <= 32'(sector_idx_q);
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!sd_ack) state_q <= NEXT;
        end
        NEXT: begin
          if (sector_idx_q == LAST_SECTOR) begin
            sector_idx_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            if (op_q == OP_LOAD) dirty_q <= 1'b0;
          end else begin
            sector_idx_q <= sector_nxt;
            sd_lba_q     <= 32'(sector_nxt);
            sd_rd_q      <= (op_q == OP_LOAD);
            sd_wr_q      <= (op_q == OP_SAVE);
            state_q      <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
      // New requests land after consumption so a same-cycle request is not lost.
      if (img_mounted) begin
        load_pend_q <= (img_size != 32'd0);
        if (!can_save) save_pend_q <= 1'b0;
      end
      if (save_queue) save_pend_q <= 1'b1;
      if (cpu_we) dirty_q <= 1'b1;
    end
  end

`ifdef CART_SRAM_AUTOSAVE_EN
  logic [31:0] idle_cnt_q;
  logic [31:0] idle_cnt_inc;

  assign idle_cnt_inc = idle_cnt_q + 32'd1;
  assign autosave_hit = dirty_q && (state_q == IDLE) &&
                        (idle_cnt_inc == 32'(AUTOSAVE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else if (cpu_we || autosave_hit) begin
      idle_cnt_q <= '0;
    end else if (dirty_q && (state_q == IDLE)) begin
      idle_cnt_q <= idle_cnt_inc;
    end
  end
`else
  logic unused_autosave_cfg;
  assign unused_autosave_cfg = (AUTOSAVE_CYCLES == 0);
  assign autosave_hit        = 1'b0;
`endif

  // RAM read registers have no reset; hide them until they have been loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_seen_q <= 1'b0;
      b_seen_q  <= 1'b0;
    end else begin
      if (cpu_oe) rd_seen_q <= 1'b1;
      b_seen_q <= 1'b1;
    end
  end

  assign cpu_dout    = rd_seen_q ? a_dout : 8'h00;
  assign sd_buff_din = b_seen_q ? b_dout : 8'h00;
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign busy        = busy_q;
  assign dirty       = dirty_q;

endmodule

// File: doc/cart_sram_backup.md
# cart_sram_backup

Battery-backed SRAM store for cartridge mappers, downstream of the mapper's sram_addr/sram_we/sram_oe outputs. Holds cartridge SRAM in dual-port block RAM, serves CPU reads and writes, and copies the whole array to and from a mounted save image over the HPS sector interface. It loads on image mount, saves on user request, and tracks a dirty flag.

## Interface
Parameters:
- ADDR_W, 13: SRAM address width; array is 2^ADDR_W bytes, ADDR_W ≥ 9.
- AUTOSAVE_CYCLES, 10_738_635: idle cycles after the last CPU write before an autosave (about 0.5 s at 21.477 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cpu_addr  in  ADDR_W  SRAM byte address from the mapper.
- cpu_din  in  8  write data.
- cpu_we  in  1  write strobe, one byte per cycle.
- cpu_oe  in  1  read enable.
- cpu_dout  out  8  read data.
- img_mounted  in  1  one-cycle pulse when a save image is (un)mounted.
- img_readonly  in  1  image is read-only; sampled with img_mounted.
- img_size  in  32  image size in bytes; sampled with img_mounted.
- save_req  in  1  one-cycle user save request.
- sd_lba  out  32  sector number.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- sd_ack  in  1  HPS transfer in progress.
- sd_buff_addr  in  9  byte index within the sector.
- sd_buff_dout  in  8  byte from HPS (load).
- sd_buff_wr  in  1  strobe for sd_buff_dout.
- sd_buff_din  out  8  byte to HPS (save).
- busy  out  1  transfer in progress.
- dirty  out  1  SRAM modified since the last save started.

## Operation
- Sector count N = 2^(ADDR_W-9). Sector k covers bytes k·512 … k·512+511.
- RAM port A is the CPU port and is never stalled, including during transfers. Port B serves HPS at address {sector_idx, sd_buff_addr}.
- On img_mounted:
  - Latch img_present = (img_size ≠ 0) and img_ro = img_readonly.
  - If img_present, queue a load.
- save_req queues a save when img_present && !img_ro. Otherwise it is ignored.
- Queued requests are held in pending bits while busy. On return to IDLE, a pending load wins over a pending save. A second request of the same kind while one is pending is merged into it.
- FSM states:
  - IDLE: start the pending load, else the pending save.
  - REQ: sd_lba = sector_idx, and sd_rd (load) or sd_wr (save) is asserted. Hold until sd_ack=1, then deassert and go to XFER.
  - XFER: stay while sd_ack=1.
    - Load: each sd_buff_wr writes sd_buff_dout into port B.
    - Save: port B continuously reads {sector_idx, sd_buff_addr}.
    - On sd_ack falling, go to NEXT.
  - NEXT: if sector_idx = N-1, clear sector_idx and go to IDLE. Otherwise increment sector_idx and go to REQ.
- dirty:
  - Set by any cpu_we.
  - Cleared on the IDLE→REQ transition of a save.
  - A cpu_we in the same cycle as that transition leaves dirty set.
  - Cleared at completion of a load.
- A load overwrites the CPU's concurrent writes to sectors not yet transferred. This is accepted behaviour.
- Unmount (img_mounted with img_size=0) during a transfer: the current transfer completes, and later saves are suppressed.

## Timing
- Reset values: cpu_dout=0, sd_lba=0, sd_rd=0, sd_wr=0, sd_buff_din=0, busy=0, dirty=0, img_present=0, pending bits=0, state IDLE. RAM contents are not cleared and survive reset.
- CPU read latency is 1 cycle: cpu_dout is registered from the address presented while cpu_oe=1 and holds its value otherwise. A write is visible to a read on the next cycle.
- sd_buff_din is valid 1 cycle after sd_buff_addr changes.
- busy=1 from the cycle after IDLE exits until the cycle NEXT returns to IDLE.
- Reset mid-transfer: sd_rd and sd_wr drop immediately. The partial image is left as is; no recovery is attempted.

## Configuration
- CART_SRAM_AUTOSAVE_EN defined:
  - An idle counter clears on cpu_we and increments while dirty && state=IDLE.
  - At AUTOSAVE_CYCLES-1 it queues a save if img_present && !img_ro, and the counter clears.
- Undefined: the counter is absent and saves occur only on save_req.

## Structure
- Package cart_sram_pkg holds:
  - the FSM state enum (IDLE, REQ, XFER, NEXT);
  - SECTOR_BYTES = 512 and SECTOR_AW = 9;
  - the op type (OP_LOAD, OP_SAVE).
- Sub-module cart_sram_dpram: true dual-port 2^ADDR_W × 8 RAM with registered reads on both ports. It has no reset.

## Test plan
- Mount with img_size=8192, ADDR_W=13 → 16 sd_rd requests with sd_lba 0…15. Bytes 0xA5 written at sector 3 offset 7 read back from cpu_addr 0x607 one cycle after cpu_oe. dirty=0 at the end.
- cpu_we 0x5A at 0x1FFF, then save_req → dirty clears at start. 16 sd_wr requests follow, and sector 15 byte 511 on sd_buff_din is 0x5A.
- save_req with img_readonly=1, or with img_size=0 → no sd_wr and busy stays 0.
- save_req and img_mounted in the same cycle while busy → after the current transfer, the load runs first, then the save.
- cpu_we at 0x0010 during a save of sector 0 → the write lands in RAM and dirty=1 after the save completes.
- With CART_SRAM_AUTOSAVE_EN and AUTOSAVE_CYCLES=100: one write, then idle → sd_wr asserts 100 cycles later. A write at cycle 50 restarts the count.
